dec_freelist: RTL and testbench
===============================

DEC_FREELIST -- requirements
Module: dec_freelist_module

Interface
REQ-001 Parameter FL_DEPTH, default 32: free-list entry count (number of PRFs minus 32 architectural); power of two.
REQ-002 Widths: PRF code width is `PRF_CODE_WIDTH (6); pointers are log2(FL_DEPTH)+1 bits (index plus wrap bit).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_fl_alloc_en  input  1  rename group fires this cycle.
REQ-006 i_fl_alloc_req_0..3  input  1 each  slot k needs a new destination PRF.
REQ-007 o_fl_alloc_prf_code_0..3  output  `PRF_CODE_WIDTH each  PRF code granted to slot k.
REQ-008 o_fl_alloc_rdy  output  1  free count covers every asserted request.
REQ-009 i_fl_ret_en_0..3  input  1 each  retiring slot k frees a PRF (dst != x0).
REQ-010 i_fl_ret_prf_code_0..3  input  `PRF_CODE_WIDTH each  freed code, i.e. the previous ARAT mapping for that dst.
REQ-011 i_fl_flush  input  1  pipeline flush; discard speculative allocations.
REQ-012 o_fl_free_cnt  output  log2(FL_DEPTH)+1  speculative free entries, 0..FL_DEPTH.

Function
REQ-013 Storage: circular buffer of FL_DEPTH codes; pointers spec_head (allocation), arch_head (committed allocation), tail (push).
REQ-014 o_fl_free_cnt = tail - spec_head, modulo 2*FL_DEPTH; combinational from registers.
REQ-015 n_req = popcount(i_fl_alloc_req_0..3); o_fl_alloc_rdy = (o_fl_free_cnt >= n_req), combinational, independent of same-cycle pushes.
REQ-016 Compaction: o_fl_alloc_prf_code_k = entry[spec_head + popcount(req_0..req_{k-1})]; valid only when req_k is set; zero-latency (same-cycle) read.
REQ-017 Allocation fires when i_fl_alloc_en & o_fl_alloc_rdy & !i_fl_flush: spec_head += n_req. If i_fl_alloc_en & !o_fl_alloc_rdy: no state change; the whole group stalls, with no partial grant.
REQ-018 Retire push: the retire-enabled slots are written compacted at tail, tail+1, ... in slot order; tail += n_ret; arch_head += n_ret.
REQ-019 Retire and allocation in the same cycle: both apply. Pushed entries are not allocatable until the next cycle.
REQ-020 Flush: spec_head <= arch_head + n_ret (this includes same-cycle retire); allocation that cycle is suppressed; tail still advances by n_ret.
REQ-021 Wrap-around: all pointer arithmetic is modulo 2*FL_DEPTH; the index is the low log2(FL_DEPTH) bits.
REQ-022 Full: count == FL_DEPTH after a push is legal. A push that would exceed FL_DEPTH is a protocol violation, and the bench flags it.
REQ-023 Invariant: arch_head never passes spec_head (count(arch_head..spec_head) >= 0); retire count never exceeds committed allocations.
REQ-024 Empty: count 0 gives o_fl_alloc_rdy = 1 only when n_req = 0.

Reset
REQ-025 On rst: entry[i] = 32+i for i in 0..FL_DEPTH-1; spec_head = arch_head = 0; tail = FL_DEPTH (wrap bit set); o_fl_free_cnt = FL_DEPTH; o_fl_alloc_rdy = 1.
REQ-026 rst takes priority over flush, allocation and retire in the same cycle.
REQ-027 Reset mid-operation discards all outstanding allocations; the next cycle shows the REQ-025 state.

Verification
REQ-028 Reset, then alloc_en with req = 1111 -> codes 32,33,34,35; next cycle free_cnt = 28.
REQ-029 Reset, then req = 1010 -> slot1 = 32, slot3 = 33; free_cnt = 30; codes 34.. remain unissued.
REQ-030 Allocate all 32 (8 groups of 4), then req = 0001 -> rdy = 0, no state change. Retire one code 5 -> next cycle rdy = 1 and slot0 = 5.
REQ-031 Allocate 8 (32..39), retire 4 (frees 1,2,3,4) with flush the same cycle -> spec_head = arch_head = 4; free_cnt = 32-4+4 = 32... next alloc of 4 returns 36,37,38,39.
REQ-032 Sustained 4-alloc/4-retire for 100 cycles across pointer wrap -> free_cnt constant; no code is issued twice while outstanding (scoreboard).
REQ-033 rst asserted together with alloc_en, retire and flush -> next cycle matches REQ-025 exactly.

Source files
------------

// File: rtl/dec_freelist_if.sv
// -----------------------------------------------------------------------------
// dec_freelist_if
//   Bundle of the rename-side allocation port, the retire-side return port,
//   the flush strobe and the free-count status of the PRF free list.
//
//   slave  : the free list itself (consumes requests/returns, drives grants)
//   master : the rename/retire logic that talks to it
//
//   i_fl_alloc_en            rename group fires this cycle
//   i_fl_alloc_req_0..3      slot k needs a new destination PRF
//   o_fl_alloc_prf_code_0..3 PRF code granted to slot k (compacted)
//   o_fl_alloc_rdy           enough free entries for every asserted request
//   i_fl_ret_en_0..3         retiring slot k frees a PRF
//   i_fl_ret_prf_code_0..3   freed code (previous ARAT mapping)
//   i_fl_flush               discard speculative allocations
//   o_fl_free_cnt            speculative free entries, 0..FL_DEPTH
// -----------------------------------------------------------------------------
`ifndef PRF_CODE_WIDTH
`define PRF_CODE_WIDTH 6
`endif

interface dec_freelist_if #(
   parameter int FL_DEPTH = 32
);
   localparam int CNT_W = $clog2(FL_DEPTH) + 1;

   logic                        i_fl_alloc_en;
   logic                        i_fl_alloc_req_0;
   logic                        i_fl_alloc_req_1;
   logic                        i_fl_alloc_req_2;
   logic                        i_fl_alloc_req_3;
   logic [`PRF_CODE_WIDTH-1:0]  o_fl_alloc_prf_code_0;
   logic [`PRF_CODE_WIDTH-1:0]  o_fl_alloc_prf_code_1;
   logic [`PRF_CODE_WIDTH-1:0]  o_fl_alloc_prf_code_2;
   logic [`PRF_CODE_WIDTH-1:0]  o_fl_alloc_prf_code_3;
   logic                        o_fl_alloc_rdy;
   logic                        i_fl_ret_en_0;
   logic                        i_fl_ret_en_1;
   logic                        i_fl_ret_en_2;
   logic                        i_fl_ret_en_3;
   logic [`PRF_CODE_WIDTH-1:0]  i_fl_ret_prf_code_0;
   logic [`PRF_CODE_WIDTH-1:0]  i_fl_ret_prf_code_1;
   logic [`PRF_CODE_WIDTH-1:0]  i_fl_ret_prf_code_2;
   logic [`PRF_CODE_WIDTH-1:0]  i_fl_ret_prf_code_3;
   logic                        i_fl_flush;
   logic [CNT_W-1:0]            o_fl_free_cnt;

   modport slave (
      input  i_fl_alloc_en,
      input  i_fl_alloc_req_0, i_fl_alloc_req_1, i_fl_alloc_req_2, i_fl_alloc_req_3,
      output o_fl_alloc_prf_code_0, o_fl_alloc_prf_code_1,
      output o_fl_alloc_prf_code_2, o_fl_alloc_prf_code_3,
      output o_fl_alloc_rdy,
      input  i_fl_ret_en_0, i_fl_ret_en_1, i_fl_ret_en_2, i_fl_ret_en_3,
      input  i_fl_ret_prf_code_0, i_fl_ret_prf_code_1,
      input  i_fl_ret_prf_code_2, i_fl_ret_prf_code_3,
      input  i_fl_flush,
      output o_fl_free_cnt
   );

   modport master (
      output i_fl_alloc_en,
      output i_fl_alloc_req_0, i_fl_alloc_req_1, i_fl_alloc_req_2, i_fl_alloc_req_3,
      input  o_fl_alloc_prf_code_0, o_fl_alloc_prf_code_1,
      input  o_fl_alloc_prf_code_2, o_fl_alloc_prf_code_3,
      input  o_fl_alloc_rdy,
      output i_fl_ret_en_0, i_fl_ret_en_1, i_fl_ret_en_2, i_fl_ret_en_3,
      output i_fl_ret_prf_code_0, i_fl_ret_prf_code_1,
      output i_fl_ret_prf_code_2, i_fl_ret_prf_code_3,
      output i_fl_flush,
      input  o_fl_free_cnt
   );
endinterface

// File: rtl/dec_freelist.sv
// -----------------------------------------------------------------------------
// dec_freelist
//   Physical-register free list for a 4-wide rename stage. A circular buffer
//   of FL_DEPTH PRF codes with three pointers:
//     spec_head : next entry handed out to rename (speculative)
//     arch_head : allocations that have been committed by retirement
//     tail      : next slot written by retirement (freed codes)
//   Pointers carry one extra wrap bit so full (FL_DEPTH) and empty (0) are
//   distinguishable. FL_DEPTH must be a power of two and at least 4.
//
// Ports
//   clk    sole clock, rising edge
//   rst    synchronous active-high reset
//   fl_if  dec_freelist_if.slave: allocation, retire, flush, free count
// -----------------------------------------------------------------------------
`ifndef PRF_CODE_WIDTH
`define PRF_CODE_WIDTH 6
`endif

module dec_freelist #(
   parameter int FL_DEPTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   dec_freelist_if.slave fl_if
);

   localparam int IDX_W  = $clog2(FL_DEPTH);
   localparam int PTR_W  = IDX_W + 1;
   localparam int CODE_W = `PRF_CODE_WIDTH;
   localparam int SLOTS  = 4;

   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [CODE_W-1:0] code_t;

   // Number of set bits of v strictly below position k: the compacted
   // offset of slot k within its group.
   function automatic ptr_t f_cnt_below(input logic [SLOTS-1:0] v, input int k);
      ptr_t acc;
      acc = '0;
      for (int j = 0; j < SLOTS; j++) begin
         if (j < k) acc = acc + ptr_t'(v[j]);
      end
      return acc;
   endfunction

   code_t r_entry [FL_DEPTH];
   ptr_t  r_spec_head;
   ptr_t  r_arch_head;
   ptr_t  r_tail;

   logic [SLOTS-1:0] w_req;
   logic [SLOTS-1:0] w_ret;
   code_t            w_ret_code [SLOTS];
   ptr_t             w_req_off  [SLOTS];
   ptr_t             w_ret_off  [SLOTS];
   idx_t             w_grant_idx[SLOTS];
   idx_t             w_ret_idx  [SLOTS];
   code_t            w_grant    [SLOTS];
   ptr_t             w_n_req;
   ptr_t             w_n_ret;
   ptr_t             w_free_cnt;
   logic             w_rdy;
   logic             w_fire;

   assign w_req = {fl_if.i_fl_alloc_req_3, fl_if.i_fl_alloc_req_2,
                   fl_if.i_fl_alloc_req_1, fl_if.i_fl_alloc_req_0};
   assign w_ret = {fl_if.i_fl_ret_en_3, fl_if.i_fl_ret_en_2,
                   fl_if.i_fl_ret_en_1, fl_if.i_fl_ret_en_0};

   assign w_ret_code[0] = fl_if.i_fl_ret_prf_code_0;
   assign w_ret_code[1] = fl_if.i_fl_ret_prf_code_1;
   assign w_ret_code[2] = fl_if.i_fl_ret_prf_code_2;
   assign w_ret_code[3] = fl_if.i_fl_ret_prf_code_3;

   assign w_n_req = f_cnt_below(w_req, SLOTS);
   assign w_n_ret = f_cnt_below(w_ret, SLOTS);

   // Modulo-2*FL_DEPTH difference; the wrap bit makes "full" read as FL_DEPTH.
   assign w_free_cnt = r_tail - r_spec_head;

   // Readiness looks only at registered state, so codes pushed by retire
   // this cycle cannot be granted until the next one.
   assign w_rdy  = (w_free_cnt >= w_n_req);
   assign w_fire = fl_if.i_fl_alloc_en & w_rdy & ~fl_if.i_fl_flush;

   always_comb begin
      for (int k = 0; k < SLOTS; k++) begin
         w_req_off[k]   = f_cnt_below(w_req, k);
         w_ret_off[k]   = f_cnt_below(w_ret, k);
         w_grant_idx[k] = idx_t'(r_spec_head + w_req_off[k]);
         w_ret_idx[k]   = idx_t'(r_tail + w_ret_off[k]);
         w_grant[k]     = r_entry[w_grant_idx[k]];
      end
   end

   assign fl_if.o_fl_alloc_prf_code_0 = w_req[0] ? w_grant[0] : '0;
   assign fl_if.o_fl_alloc_prf_code_1 = w_req[1] ? w_grant[1] : '0;
   assign fl_if.o_fl_alloc_prf_code_2 = w_req[2] ? w_grant[2] : '0;
   assign fl_if.o_fl_alloc_prf_code_3 = w_req[3] ? w_grant[3] : '0;
   assign fl_if.o_fl_alloc_rdy        = w_rdy;
   assign fl_if.o_fl_free_cnt         = w_free_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         // Architectural registers own PRFs 0..31; the rest start out free.
         for (int i = 0; i < FL_DEPTH; i++) begin
            r_entry[i] <= code_t'(32 + i);
         end
         r_spec_head <= '0;
         r_arch_head <= '0;
         r_tail      <= ptr_t'(FL_DEPTH);
      end else begin
         for (int k = 0; k < SLOTS; k++) begin
            if (w_ret[k]) r_entry[w_ret_idx[k]] <= w_ret_code[k];
         end
         r_tail      <= r_tail + w_n_ret;
         r_arch_head <= r_arch_head + w_n_ret;
         // Flush rewinds to the committed point, including this cycle's
         // retirements, which also commit their own allocations.
         if (fl_if.i_fl_flush) begin
            r_spec_head <= r_arch_head + w_n_ret;
         end else if (w_fire) begin
            r_spec_head <= r_spec_head + w_n_req;
         end
      end
   end

endmodule

// File: tb/tb_dec_freelist.sv
module tb_dec_freelist;
   localparam int FL_DEPTH = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dec_freelist_if #(.FL_DEPTH(FL_DEPTH)) fl_if();

   dec_freelist #(.FL_DEPTH(FL_DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .fl_if (fl_if)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   // Reference model: q holds the codes from the committed allocation point
   // onward, oldest first (always FL_DEPTH long). The first nspec of them
   // are handed out speculatively; the rest are free. arch_q holds the codes
   // currently mapped by the architectural registers.
   int q[$];
   int arch_q[$];
   int nspec;

   task automatic model_reset();
      q.delete();
      arch_q.delete();
      for (int i = 0; i < FL_DEPTH; i++) q.push_back(32 + i);
      for (int i = 0; i < 32; i++) arch_q.push_back(i);
      nspec = 0;
   endtask

   function automatic bit is_live(input int c);
      foreach (arch_q[i]) if (arch_q[i] == c) return 1'b1;
      for (int i = 0; i < nspec; i++) if (q[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive(input bit en, input bit [3:0] req, input bit [3:0] ret,
                        input bit [3:0][5:0] rc, input bit fl, input bit rs);
      rst                       = rs;
      fl_if.i_fl_alloc_en       = en;
      fl_if.i_fl_alloc_req_0    = req[0];
      fl_if.i_fl_alloc_req_1    = req[1];
      fl_if.i_fl_alloc_req_2    = req[2];
      fl_if.i_fl_alloc_req_3    = req[3];
      fl_if.i_fl_ret_en_0       = ret[0];
      fl_if.i_fl_ret_en_1       = ret[1];
      fl_if.i_fl_ret_en_2       = ret[2];
      fl_if.i_fl_ret_en_3       = ret[3];
      fl_if.i_fl_ret_prf_code_0 = rc[0];
      fl_if.i_fl_ret_prf_code_1 = rc[1];
      fl_if.i_fl_ret_prf_code_2 = rc[2];
      fl_if.i_fl_ret_prf_code_3 = rc[3];
      fl_if.i_fl_flush          = fl;
   endtask

   // One clock cycle: apply inputs, compare outputs with the model, then
   // advance the model across the rising edge. Observed values are returned
   // for directed constant checks.
   task automatic step(input bit en, input bit [3:0] req, input bit [3:0] ret,
                       input bit [3:0][5:0] rc, input bit fl, input bit rs,
                       output bit [3:0][5:0] oc, output bit ordy, output int ocnt);
      int  nreq, nret, exp_free, off, c;
      int  fidx[$];
      bit  exp_rdy, fire;
      @(negedge clk);
      drive(en, req, ret, rc, fl, rs);
      #1;
      nreq     = $countones(req);
      nret     = $countones(ret);
      exp_free = FL_DEPTH - nspec;
      exp_rdy  = (exp_free >= nreq);
      ocnt     = int'(fl_if.o_fl_free_cnt);
      ordy     = fl_if.o_fl_alloc_rdy;
      oc       = {fl_if.o_fl_alloc_prf_code_3, fl_if.o_fl_alloc_prf_code_2,
                  fl_if.o_fl_alloc_prf_code_1, fl_if.o_fl_alloc_prf_code_0};
      chk("free_cnt", ocnt, exp_free);
      chk("alloc_rdy", int'(ordy), int'(exp_rdy));
      fire = en && exp_rdy && !fl && !rs;
      off  = 0;
      for (int k = 0; k < 4; k++) begin
         if (req[k]) begin
            if (exp_rdy) chk($sformatf("code%0d", k), int'(oc[k]), q[nspec + off]);
            if (fire)    chk($sformatf("code%0d_not_live", k), int'(is_live(int'(oc[k]))), 0);
            off++;
         end
      end
      if (!rs) chk("ret_within_committable", int'(nret <= nspec), 1);
      @(posedge clk);
      if (rs) begin
         model_reset();
      end else begin
         if (fire) nspec += nreq;
         for (int k = 0; k < 4; k++) begin
            if (ret[k]) begin
               q.push_back(int'(rc[k]));
               c    = q.pop_front();
               fidx = arch_q.find_first_index(x) with (x == int'(rc[k]));
               if (fidx.size() > 0) arch_q.delete(fidx[0]);
               arch_q.push_back(c);
            end
         end
         nspec -= nret;
         if (nspec < 0) nspec = 0;
         if (fl) nspec = 0;
      end
      #1;
      drive(1'b0, 4'b0, 4'b0, '0, 1'b0, 1'b0);
   endtask

   // Pick retirements: up to n_max slots, each freeing a distinct code that
   // an architectural register currently maps.
   task automatic gen_ret(input int n_max, input bit all4,
                          output bit [3:0] ret, output bit [3:0][5:0] rc);
      int tmp[$];
      int cnt, idx;
      tmp = arch_q;
      ret = '0;
      rc  = '0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if ((all4 || $urandom_range(0, 1) == 1) && cnt < n_max) begin
            idx    = $urandom_range(0, tmp.size() - 1);
            ret[k] = 1'b1;
            rc[k]  = 6'(tmp[idx]);
            tmp.delete(idx);
            cnt++;
         end
      end
   endtask

   bit [3:0][5:0] oc, rc;
   bit [3:0]      ret;
   bit            ordy;
   int            ocnt;

   initial begin
      drive(1'b0, 4'b0, 4'b0, '0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // Reset state, observed with a 4-wide request that is not enabled.
      step(0, 4'b1111, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("rst_cnt", ocnt, 32);
      chk("rst_rdy", int'(ordy), 1);
      chk("rst_code0", int'(oc[0]), 32);
      chk("rst_code3", int'(oc[3]), 35);

      // Four-wide allocation from reset.
      step(1, 4'b1111, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("a4_code0", int'(oc[0]), 32);
      chk("a4_code1", int'(oc[1]), 33);
      chk("a4_code2", int'(oc[2]), 34);
      chk("a4_code3", int'(oc[3]), 35);
      step(0, 4'b0, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("a4_cnt", ocnt, 28);

      // Sparse request 1010 is compacted.
      step(0, 4'b0, 4'b0, '0, 0, 1, oc, ordy, ocnt);
      step(1, 4'b1010, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("sparse_slot1", int'(oc[1]), 32);
      chk("sparse_slot3", int'(oc[3]), 33);
      step(0, 4'b0001, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("sparse_cnt", ocnt, 30);
      chk("sparse_next", int'(oc[0]), 34);

      // Exhaust the list, stall, then one retirement makes room.
      step(0, 4'b0, 4'b0, '0, 0, 1, oc, ordy, ocnt);
      repeat (8) step(1, 4'b1111, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      step(1, 4'b0001, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("empty_rdy", int'(ordy), 0);
      chk("empty_cnt", ocnt, 0);
      step(1, 4'b0000, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("empty_rdy_noreq", int'(ordy), 1);
      rc = '0;
      rc[0] = 6'd5;
      step(0, 4'b0, 4'b0001, rc, 0, 0, oc, ordy, ocnt);
      step(1, 4'b0001, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("refill_rdy", int'(ordy), 1);
      chk("refill_code", int'(oc[0]), 5);

      // Retire four with a same-cycle flush.
      step(0, 4'b0, 4'b0, '0, 0, 1, oc, ordy, ocnt);
      repeat (2) step(1, 4'b1111, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      rc = {6'd4, 6'd3, 6'd2, 6'd1};
      step(1, 4'b1111, 4'b1111, rc, 1, 0, oc, ordy, ocnt);
      step(0, 4'b0, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("flush_cnt", ocnt, 32);
      step(1, 4'b1111, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("flush_code0", int'(oc[0]), 36);
      chk("flush_code3", int'(oc[3]), 39);

      // Reset wins over everything else in the same cycle.
      gen_ret(nspec, 1'b1, ret, rc);
      step(1, 4'b1111, ret, rc, 1, 1, oc, ordy, ocnt);
      step(0, 4'b1111, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      chk("rstprio_cnt", ocnt, 32);
      chk("rstprio_rdy", int'(ordy), 1);
      chk("rstprio_code0", int'(oc[0]), 32);
      chk("rstprio_code2", int'(oc[2]), 34);

      // Sustained 4-in/4-out across several pointer wraps.
      repeat (2) step(1, 4'b1111, 4'b0, '0, 0, 0, oc, ordy, ocnt);
      for (int i = 0; i < 100; i++) begin
         gen_ret(nspec, 1'b1, ret, rc);
         step(1, 4'b1111, ret, rc, 0, 0, oc, ordy, ocnt);
         chk("sustain_cnt", ocnt, 24);
      end

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         bit [3:0] req;
         bit       en, fl, rs;
         en  = ($urandom_range(0, 3) != 0);
         req = 4'($urandom);
         fl  = ($urandom_range(0, 19) == 0);
         rs  = ($urandom_range(0, 149) == 0);
         gen_ret((nspec < 4) ? nspec : 4, 1'b0, ret, rc);
         step(en, req, ret, rc, fl, rs, oc, ordy, ocnt);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
